// File: rtl/pulse_frame_scheduler_pkg.sv
// Purpose: shared FSM encodings and counter-width helper for the pulse frame scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pulse_frame_scheduler_pkg;

    // Frame sequencing states; the encodings are fixed so debug probes decode consistently.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Width of a down-counter or index spanning 0..n-1, never narrower than one bit.
    // Bit counter uses cnt_w(WIDTH), gap counter cnt_w(GAP+1), requester index cnt_w(N_REQ).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_frame_scheduler_rr_arbiter.sv
// Purpose: round-robin pick of the first set request at or after the pointer, wrapping upward.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter
    import pulse_frame_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = cnt_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    // Scan N_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        int j;
        winner  = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!any_req && req[j]) begin
                any_req = 1'b1;
                winner  = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/pulse_frame_scheduler.sv
// Purpose: shares one pulse_generator between N_REQ requesters, round-robin, one frame at a time.
// Latency: req sampled at edge t -> pg_load in cycle t+1 -> ack in cycle t+1+WIDTH.
// Backpressure: requesters hold req until ack; new requests are only sampled in IDLE.
module pulse_frame_scheduler
    import pulse_frame_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                     Clk,
    input  logic                     Clr,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   value_i,
    output logic [N_REQ-1:0]         ack,
    output logic [cnt_w(N_REQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     pg_load,
    output logic [WIDTH-1:0]         pg_value,
    output logic                     frame_done
);

    localparam int IDX_W = cnt_w(N_REQ);
    localparam int BIT_W = cnt_w(WIDTH);
    localparam int GAP_W = cnt_w(GAP + 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [IDX_W-1:0]   winner;
    logic               any_req;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign grant_id = grant_q;

    // State and datapath registers; Clr aborts any frame in flight without acking it.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state and outputs; outputs decode from state only so they drop as soon as Clr does.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        data_d     = data_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        busy       = 1'b0;
        pg_load    = 1'b0;
        pg_value   = '0;
        frame_done = 1'b0;
        ack        = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    data_d  = value_i[int'(winner)*WIDTH +: WIDTH];
                    ptr_d   = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                busy      = 1'b1;
                pg_load   = 1'b1;
                pg_value  = data_q;
                bit_cnt_d = BIT_W'(WIDTH - 1);
                state_d   = ST_SHIFT;
            end

            ST_SHIFT: begin
                busy = 1'b1;
                if (bit_cnt_q == '0) begin
                    // Last shift cycle: complete the frame towards the granted requester.
                    frame_done   = 1'b1;
                    ack[grant_q] = 1'b1;
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = GAP_W'(GAP - 1);
                        state_d   = ST_GAP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end
            end

            ST_GAP: begin
                busy = 1'b1;
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/pulse_frame_scheduler.md
Name: pulse_frame_scheduler

Overview:
Shares one pulse_generator shift-out resource between N_REQ requesters using round-robin arbitration. Captures the winner's WIDTH-bit pattern and drives the generator's load/value inputs for exactly one cycle. Counts out the WIDTH shift cycles, then acknowledges the requester. Sits between requesting control logic and the pulse_generator instance, on the same Clk.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, pattern width; equals pulse_generator shift length
GAP, 1, idle cycles inserted between frames (0..15; 0 = back-to-back)

Ports:
Clk  input  1  rising-edge clock
Clr  input  1  asynchronous active-high reset
req  input  N_REQ  per-requester request, level; held high until its ack
value_i  input  N_REQ*WIDTH  pattern of requester i at bits [i*WIDTH +: WIDTH]
ack  output  N_REQ  one-cycle completion pulse to the granted requester
grant_id  output  clog2(N_REQ)  index of the current/last granted requester
busy  output  1  high in LOAD, SHIFT, GAP
pg_load  output  1  to pulse_generator load
pg_value  output  WIDTH  to pulse_generator value
frame_done  output  1  one-cycle pulse, coincident with ack

Behaviour:
- Reset (Clr high, asynchronous): state IDLE, rr pointer 0, grant_id 0, data register 0. ack, busy, pg_load, pg_value and frame_done are 0 immediately.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE: at a rising edge with any req bit sampled high:
  - winner = first set req at or after the pointer, scanning upward mod N_REQ.
  - grant_id <= winner; data register <= value_i slice of winner; pointer <= (winner+1) mod N_REQ; state <= LOAD.
  - With no req set, stay in IDLE with the pointer unchanged.
- LOAD: exactly 1 cycle. pg_load=1, pg_value=data register. Next state SHIFT with bit counter = WIDTH-1.
- SHIFT: WIDTH cycles. pg_load=0, pg_value=0.
  - Counter decrements each cycle.
  - In the cycle with counter==0: ack[grant_id]=1 and frame_done=1 (combinational from state and counter).
  - Next state is GAP with gap counter = GAP-1, or IDLE if GAP=0.
- GAP: GAP cycles, outputs idle, busy=1. Then IDLE.
- pg_value is 0 in every cycle except LOAD. pg_load is never high for two consecutive cycles.
- Latency: req sampled at edge t → pg_load high in cycle t+1 → ack in cycle t+1+WIDTH. Frame period = 1+WIDTH+GAP cycles, plus 1 IDLE arbitration cycle.
- Requester rules:
  - req and value_i must stay stable until ack; req must be low in the cycle after ack.
  - A req still high after ack is a new request.
  - Dropping req after grant does not abort the frame; ack is still issued.
  - Dropping req before grant means no grant.
- Simultaneous requests: strictly round-robin from the pointer. No requester waits more than N_REQ-1 frames.
- Clr mid-frame: frame aborted, no ack, pointer returns to 0. The downstream pulse_generator is not cleared by this block.
- Only one ack bit is ever high, and only in SHIFT.

Decomposition:
- Shared include pulse_sched_defs: state encodings (IDLE=0, LOAD=1, SHIFT=2, GAP=3) and counter width localparams (clog2(WIDTH), clog2(GAP+1)).
- One sub-module, rr_arbiter: inputs req and pointer; outputs winner index and any_req. Purely combinational, N_REQ-parameterised.
- The pointer register lives in pulse_frame_scheduler.

Test Plan:
- Reset state: Clr pulse mid-cycle → all outputs 0 without waiting for a Clk edge; grant_id=0.
- Single request: req=4'b0100, value_i[23:16]=8'hA5 → pg_load=1 with pg_value=8'hA5 one cycle after the sampling edge; ack=4'b0100 and frame_done exactly 9 cycles after that edge; busy high for 10 cycles (GAP=1).
- Round-robin: req=4'b1111 held, each requester dropping after its own ack → grant order 0,1,2,3,0; frame starts 11 cycles apart (GAP=1).
- Pointer skip: after grant to 1, req=4'b0011 → requester 0 granted next, pointer becomes 1.
- Withdrawal: req[2] dropped one cycle after its pg_load → ack[2] still issued at the normal cycle. Separately, req[3] pulsed for 0 sampled edges while busy → never granted.
- Abort: Clr asserted during SHIFT counter=3 → no ack, state IDLE. A following req=4'b0010 → normal frame, ack[1].
